// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - EV22 program counter sequencer with subroutine return stack
// Optional single-step mode: define SINGLE_STEP_EN to add the STEP input and WAIT_STEP state.
module pc_sequencer #(
    parameter int          ADDR_W      = 12,
    parameter int          STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             MEM_RDY,
    input  logic                             JUMP,
    input  logic                             SR,
    input  logic [ADDR_W-1:0]                TARGET,
    input  logic                             HALT_REQ,
`ifdef SINGLE_STEP_EN
    input  logic                             STEP,
`endif
    output logic [ADDR_W-1:0]                PC,
    output logic                             FETCH_REQ,
    output logic                             IR_LOAD,
    output logic                             EXEC,
    output logic [$clog2(STACK_DEPTH):0]     SP,
    output logic                             STK_ERR,
    output logic                             HALTED
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {IDLE, FETCH, EXECUTE, HALT, WAIT_STEP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, EXECUTE, HALT} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic [SP_W-1:0]   sp, sp_nxt, sp_dec;
    logic              stk_err;
    logic              err_set;
    logic              push;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    assign pc_inc = pc + ADDR_W'(1);
    assign sp_dec = sp - SP_W'(1);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        err_set   = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (MEM_RDY) state_nxt = EXECUTE;
            EXECUTE: begin
                case ({JUMP, SR})
                    2'b10: pc_nxt = TARGET;
                    2'b11: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            err_set = 1'b1;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                            pc_nxt = TARGET;
                        end
                    end
                    2'b01: begin
                        if (sp == '0) begin
                            err_set = 1'b1;
                        end else begin
                            sp_nxt = sp_dec;
                            pc_nxt = stack[sp_dec[IDX_W-1:0]];
                        end
                    end
                    default: pc_nxt = pc_inc;
                endcase
                if (HALT_REQ || err_set) begin
                    state_nxt = HALT;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_nxt = WAIT_STEP;
`else
                    state_nxt = FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            WAIT_STEP: begin
                if (HALT_REQ) begin
                    state_nxt = HALT;
                end else if (STEP) begin
                    state_nxt = FETCH;
                end
            end
`endif
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them without a clock edge.
    assign FETCH_REQ = (state == FETCH);
    assign IR_LOAD   = (state == FETCH) && MEM_RDY;
    assign EXEC      = (state == EXECUTE);
    assign HALTED    = (state == HALT);
    assign PC        = pc;
    assign SP        = sp;
    assign STK_ERR   = stk_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            pc      <= ADDR_W'(RESET_PC);
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            sp    <= sp_nxt;
            if (err_set) begin
                stk_err <= 1'b1;
            end
        end
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        MEM_RDY = 1'b0;
    logic        JUMP = 1'b0;
    logic        SR = 1'b0;
    logic [11:0] TARGET = '0;
    logic        HALT_REQ = 1'b0;
    logic [11:0] PC;
    logic        FETCH_REQ;
    logic        IR_LOAD;
    logic        EXEC;
    logic [3:0]  SP;
    logic        STK_ERR;
    logic        HALTED;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] m_pc;
    logic [11:0] m_stack [$];
    logic        m_err;
    logic        m_halted;

    pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .MEM_RDY(MEM_RDY), .JUMP(JUMP), .SR(SR),
        .TARGET(TARGET), .HALT_REQ(HALT_REQ), .PC(PC), .FETCH_REQ(FETCH_REQ),
        .IR_LOAD(IR_LOAD), .EXEC(EXEC), .SP(SP), .STK_ERR(STK_ERR), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pc = 12'h000;
        m_stack.delete();
        m_err = 1'b0;
        m_halted = 1'b0;
    endtask

    // Instruction-level behaviour: one call per executed instruction.
    task automatic model_exec(input bit j, input bit s, input logic [11:0] tgt, input bit h);
        bit err;
        err = 1'b0;
        if (j && !s) begin
            m_pc = tgt;
        end else if (j && s) begin
            if (m_stack.size() == DEPTH) err = 1'b1;
            else begin
                m_stack.push_back(12'((int'(m_pc) + 1) % 4096));
                m_pc = tgt;
            end
        end else if (!j && s) begin
            if (m_stack.size() == 0) err = 1'b1;
            else m_pc = m_stack.pop_back();
        end else begin
            m_pc = 12'((int'(m_pc) + 1) % 4096);
        end
        if (err) m_err = 1'b1;
        m_halted = h || err;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0; MEM_RDY = 0; JUMP = 0; SR = 0; HALT_REQ = 0; TARGET = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    // Drives one fetch/execute pair; ok reports the handshake shape, no model checks here.
    task automatic exec_instr(input bit j, input bit s, input logic [11:0] tgt, input bit h,
                              input int waits, output bit ok, output logic [11:0] fpc, output int cyc);
        ok = 1'b1;
        cyc = 0;
        while (FETCH_REQ !== 1'b1 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        if (FETCH_REQ !== 1'b1) begin
            ok = 1'b0;
            fpc = 'x;
            return;
        end
        fpc = PC;
        for (int i = 0; i < waits; i++) begin
            MEM_RDY = 1'b0;
            @(negedge CLK);
            if (FETCH_REQ !== 1'b1 || PC !== fpc || IR_LOAD !== 1'b0 || EXEC !== 1'b0) ok = 1'b0;
        end
        MEM_RDY = 1'b1; JUMP = j; SR = s; TARGET = tgt; HALT_REQ = h;
        #1;
        if (IR_LOAD !== 1'b1) ok = 1'b0;
        @(negedge CLK);
        MEM_RDY = 1'b0;
        if (EXEC !== 1'b1 || FETCH_REQ !== 1'b0 || IR_LOAD !== 1'b0 || PC !== fpc) ok = 1'b0;
        @(negedge CLK);
        JUMP = 1'b0; SR = 1'b0; HALT_REQ = 1'b0;
        if (EXEC !== 1'b0) ok = 1'b0;
        model_exec(j, s, tgt, h);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({PC, SP, FETCH_REQ, IR_LOAD, EXEC, STK_ERR, HALTED} !== {12'h000, 4'd0, 5'b00000})
            $display("FAIL reset_values: got pc=%h sp=%0d f=%b i=%b e=%b err=%b h=%b want all zero",
                     PC, SP, FETCH_REQ, IR_LOAD, EXEC, STK_ERR, HALTED);
        else n_pass++;
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (FETCH_REQ !== 1'b0) $display("FAIL idle_no_fetch: got %b want 0", FETCH_REQ);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (FETCH_REQ !== 1'b1 || PC !== 12'h000)
            $display("FAIL first_fetch: got req=%b pc=%h want 1 000", FETCH_REQ, PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        bit ok; logic [11:0] fpc; int cyc;
        for (int i = 0; i < 4; i++) begin
            exec_instr(0, 0, 12'h000, 0, 0, ok, fpc, cyc);
            n_checks++;
            if (!ok || fpc !== 12'(i) || cyc != 0)
                $display("FAIL seq_%0d: got ok=%b pc=%h gap=%0d want 1 %h 0", i, ok, fpc, cyc, 12'(i));
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        bit ok; logic [11:0] fpc; int cyc;
        exec_instr(0, 0, 12'h000, 0, 5, ok, fpc, cyc);
        n_checks++;
        if (!ok || fpc !== 12'h004)
            $display("FAIL wait_states: got ok=%b pc=%h want 1 004", ok, fpc);
        else n_pass++;
        n_checks++;
        if (PC !== m_pc) $display("FAIL wait_next_pc: got %h want %h", PC, m_pc);
        else n_pass++;
    endtask

    task automatic test_bsr_ret();
        bit ok; logic [11:0] fpc; int cyc;
        exec_instr(1, 0, 12'h010, 0, 0, ok, fpc, cyc);
        exec_instr(1, 1, 12'h200, 0, 1, ok, fpc, cyc);
        n_checks++;
        if (!ok || PC !== 12'h200 || SP !== 4'd1 || PC !== m_pc)
            $display("FAIL bsr: got ok=%b pc=%h sp=%0d want 1 200 1", ok, PC, SP);
        else n_pass++;
        exec_instr(0, 0, 12'h000, 0, 0, ok, fpc, cyc);
        exec_instr(0, 1, 12'h777, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (!ok || PC !== 12'h011 || SP !== 4'd0 || PC !== m_pc)
            $display("FAIL ret: got ok=%b pc=%h sp=%0d want 1 011 0", ok, PC, SP);
        else n_pass++;
    endtask

    task automatic test_jump_wrap();
        bit ok; logic [11:0] fpc; int cyc;
        exec_instr(1, 1, 12'hFFF, 0, 0, ok, fpc, cyc);
        exec_instr(0, 0, 12'h000, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (!ok || PC !== 12'h000 || PC !== m_pc)
            $display("FAIL pc_wrap: got ok=%b pc=%h want 1 000", ok, PC);
        else n_pass++;
        exec_instr(1, 0, 12'h123, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (!ok || PC !== 12'h123 || SP !== 4'd1)
            $display("FAIL jump: got ok=%b pc=%h sp=%0d want 1 123 1", ok, PC, SP);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok; logic [11:0] fpc; int cyc;
        bit j, s;
        logic [11:0] tgt;
        int bad = 0;
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            j = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if (j && s && m_stack.size() == DEPTH) s = 1'b0;
            if (!j && s && m_stack.size() == 0) s = 1'b0;
            tgt = 12'($urandom);
            exec_instr(j, s, tgt, 0, $urandom_range(0, 2), ok, fpc, cyc);
            n_checks++;
            if (!ok || {PC, SP, STK_ERR, HALTED} !== {m_pc, 4'(m_stack.size()), m_err, m_halted}) begin
                $display("FAIL random_%0d: got ok=%b pc=%h sp=%0d err=%b h=%b want pc=%h sp=%0d err=%b h=%b",
                         n, ok, PC, SP, STK_ERR, HALTED, m_pc, m_stack.size(), m_err, m_halted);
                bad++;
            end else n_pass++;
            if (bad > 5) break;
        end
    endtask

    task automatic test_overflow();
        bit ok; logic [11:0] fpc; int cyc;
        logic [11:0] last;
        apply_reset();
        for (int n = 0; n < DEPTH; n++)
            exec_instr(1, 1, 12'($urandom), 0, 0, ok, fpc, cyc);
        n_checks++;
        if (SP !== 4'd8 || STK_ERR !== 1'b0 || PC !== m_pc)
            $display("FAIL stack_full: got sp=%0d err=%b pc=%h want 8 0 %h", SP, STK_ERR, PC, m_pc);
        else n_pass++;
        last = PC;
        exec_instr(1, 1, 12'hABC, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (STK_ERR !== 1'b1 || HALTED !== 1'b1 || PC !== last || SP !== 4'd8 || FETCH_REQ !== 1'b0)
            $display("FAIL overflow: got err=%b h=%b pc=%h sp=%0d f=%b want 1 1 %h 8 0",
                     STK_ERR, HALTED, PC, SP, FETCH_REQ, last);
        else n_pass++;
        MEM_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        MEM_RDY = 1'b0;
        n_checks++;
        if (HALTED !== 1'b1 || PC !== last || FETCH_REQ !== 1'b0 || EXEC !== 1'b0)
            $display("FAIL halt_frozen: got h=%b pc=%h f=%b e=%b want 1 %h 0 0", HALTED, PC, FETCH_REQ, EXEC, last);
        else n_pass++;
    endtask

    task automatic test_underflow();
        bit ok; logic [11:0] fpc; int cyc;
        apply_reset();
        exec_instr(0, 1, 12'h055, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (STK_ERR !== 1'b1 || HALTED !== 1'b1 || PC !== 12'h000 || SP !== 4'd0 || m_err !== 1'b1)
            $display("FAIL underflow: got err=%b h=%b pc=%h sp=%0d want 1 1 000 0", STK_ERR, HALTED, PC, SP);
        else n_pass++;
    endtask

    task automatic test_halt_req();
        bit ok; logic [11:0] fpc; int cyc;
        apply_reset();
        HALT_REQ = 1'b1;
        exec_instr(0, 0, 12'h000, 0, 3, ok, fpc, cyc);
        n_checks++;
        if (!ok || HALTED !== 1'b0 || PC !== 12'h001)
            $display("FAIL halt_in_fetch_ignored: got ok=%b h=%b pc=%h want 1 0 001", ok, HALTED, PC);
        else n_pass++;
        exec_instr(0, 0, 12'h000, 1, 0, ok, fpc, cyc);
        n_checks++;
        if (HALTED !== 1'b1 || FETCH_REQ !== 1'b0 || PC !== m_pc || m_halted !== 1'b1)
            $display("FAIL halt_req: got h=%b f=%b pc=%h want 1 0 %h", HALTED, FETCH_REQ, PC, m_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok; logic [11:0] fpc; int cyc;
        apply_reset();
        exec_instr(1, 1, 12'h050, 0, 0, ok, fpc, cyc);
        exec_instr(0, 0, 12'h000, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (FETCH_REQ !== 1'b1 || PC !== 12'h051 || SP !== 4'd1)
            $display("FAIL pre_reset_fetch: got f=%b pc=%h sp=%0d want 1 051 1", FETCH_REQ, PC, SP);
        else n_pass++;
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({PC, SP, FETCH_REQ, IR_LOAD, EXEC, STK_ERR, HALTED} !== {12'h000, 4'd0, 5'b00000})
            $display("FAIL async_reset: got pc=%h sp=%0d f=%b i=%b e=%b err=%b h=%b want all zero",
                     PC, SP, FETCH_REQ, IR_LOAD, EXEC, STK_ERR, HALTED);
        else n_pass++;
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        exec_instr(0, 0, 12'h000, 0, 0, ok, fpc, cyc);
        n_checks++;
        if (!ok || fpc !== 12'h000)
            $display("FAIL post_reset_fetch: got ok=%b pc=%h want 1 000", ok, fpc);
        else n_pass++;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_sequential();
        test_wait_states();
        test_bsr_ret();
        test_jump_wrap();
        test_random();
        test_overflow();
        test_underflow();
        test_halt_req();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and subroutine-return-stack controller for the EV22 core. It sequences fetch/execute and requests instruction words from program memory over a ready handshake. In execute it consumes the branch-decision pair (JUMP = branch taken, SR = subroutine flag) and the jump target, and updates the PC. BSR pushes the return address onto an internal LIFO; RET pops it.

Parameters:
ADDR_W, 12, program address width in bits
STACK_DEPTH, 8, return-stack entries (power of 2, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
MEM_RDY  in  1  program memory has instruction word valid this cycle
JUMP  in  1  branch taken (from branch-condition block)
SR  in  1  subroutine flag (from branch-condition block)
TARGET  in  ADDR_W  jump/BSR destination address
HALT_REQ  in  1  stop after current instruction
PC  out  ADDR_W  current program counter
FETCH_REQ  out  1  fetch request to program memory
IR_LOAD  out  1  one-cycle strobe: latch instruction register
EXEC  out  1  high during execute state
SP  out  log2(STACK_DEPTH)+1  return-stack occupancy
STK_ERR  out  1  sticky overflow/underflow flag
HALTED  out  1  sequencer stopped

Behaviour:
- Reset (async, RST_N=0): PC=RESET_PC, SP=0, FETCH_REQ=0, IR_LOAD=0, EXEC=0, STK_ERR=0, HALTED=0, state=IDLE. Stack contents are not cleared.
- States: IDLE, FETCH, EXECUTE, HALT.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: FETCH_REQ=1, PC held stable.
  - MEM_RDY=1: IR_LOAD=1 for that cycle, -> EXECUTE.
  - MEM_RDY=0: stay in FETCH; no timeout.
- EXECUTE: EXEC=1 for exactly one cycle. JUMP/SR are sampled this cycle and PC updates at the cycle's end:
  - JUMP=1, SR=0 (JMP/JCY/JNE/JZE taken): PC<=TARGET.
  - JUMP=1, SR=1 (BSR): stack[SP]<=PC+1, SP<=SP+1, PC<=TARGET.
  - JUMP=0, SR=1 (RET): SP<=SP-1, PC<=stack[SP-1].
  - JUMP=0, SR=0: PC<=PC+1.
  - Then -> HALT if HALT_REQ=1 or a stack error occurred this cycle; else -> FETCH.
- PC arithmetic is modulo 2^ADDR_W; PC+1 from all-ones wraps to 0, with no flag.
- Overflow (BSR with SP==STACK_DEPTH): no push, PC and SP unchanged, STK_ERR<=1, -> HALT.
- Underflow (RET with SP==0): PC and SP unchanged, STK_ERR<=1, -> HALT.
- HALT: HALTED=1, FETCH_REQ=0, PC frozen. Only reset exits.
- HALT_REQ is sampled only in EXECUTE. Asserting it in FETCH has no effect until the following EXECUTE.
- Reset mid-fetch: FETCH_REQ drops asynchronously, and the first request after reset is at RESET_PC.
- Latency: a zero-wait-state fetch gives 2 cycles per instruction (FETCH, EXECUTE).

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input STEP (1 bit) and state WAIT_STEP.
  - After EXECUTE (when not halting), go to WAIT_STEP instead of FETCH.
  - Leave WAIT_STEP for FETCH on the cycle STEP=1.
  - HALT_REQ=1 while in WAIT_STEP -> HALT.
  - EXEC=0 and FETCH_REQ=0 while in WAIT_STEP.
- Undefined: no STEP port and no WAIT_STEP state; EXECUTE goes directly to FETCH.

Test Plan:
- Reset release, MEM_RDY tied 1, JUMP=SR=0 -> PC sequence 0,1,2,3 with one EXEC pulse every 2 cycles; IR_LOAD coincides with each FETCH exit.
- MEM_RDY held 0 for 5 cycles in FETCH at PC=4 -> FETCH_REQ high and PC=4 throughout; EXECUTE entered on the cycle after MEM_RDY=1.
- PC=0x010, BSR with TARGET=0x200 -> PC=0x200, SP=1, stack[0]=0x011. Later RET -> PC=0x011, SP=0.
- STACK_DEPTH=8: nine nested BSRs -> the first 8 push (SP=8); the 9th sets STK_ERR=1 and HALTED=1 with PC unchanged. After reset, a RET with SP=0 gives STK_ERR=1 and PC unchanged.
- PC=0xFFF with no branch -> PC=0x000. JUMP=1, SR=0, TARGET=0x123 -> PC=0x123, SP unchanged.
- HALT_REQ=1 during EXECUTE -> HALTED=1 and FETCH_REQ=0 next cycle. Pulse RST_N low mid-FETCH -> all outputs return to reset values immediately, without waiting for a CLK edge.
